// File: rtl/bw_io_cmos_pad_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bw_io_cmos_pad_ctl
// Purpose  : Sequencing controller for one bidirectional CMOS pad slice.
//            Transmit side takes bits from the core over valid/ready, holds
//            each bit on the edge cell for HOLD_CYC cycles, and inserts
//            TURN_CYC bus-turnaround cycles before releasing the pad.
//            Receive side synchronises the edge cell's to_core output,
//            glitch-filters it, and masks the pad's own echo while driving.
// Ports    : clk       - core clock, rising edge
//            reset     - synchronous active-high reset
//            por       - power-on reset from edge cell (aborts driving)
//            bsr_mode  - boundary-scan mode (inhibits new transmits)
//            tx_valid  - core has a bit to send
//            tx_data   - bit to send
//            tx_ready  - bit accepted this cycle when tx_valid is high
//            pad_data  - edge cell data pin
//            pad_oe    - edge cell output-enable pin
//            rcvr_in   - edge cell to_core (asynchronous)
//            rx_data   - filtered received level
//            rx_edge   - one-cycle pulse when rx_data changes
//            busy      - high while driving or turning the bus around
// Revision : 1.0 - initial release
// ============================================================================
module bw_io_cmos_pad_ctl #(
    parameter int HOLD_CYC = 2,
    parameter int TURN_CYC = 1,
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic por,
    input  logic bsr_mode,
    input  logic tx_valid,
    input  logic tx_data,
    output logic tx_ready,
    output logic pad_data,
    output logic pad_oe,
    input  logic rcvr_in,
    output logic rx_data,
    output logic rx_edge,
    output logic busy
);

    // One counter width serves both the hold/turn counter and the filter.
    localparam int c_max_ht  = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
    localparam int c_max_all = (c_max_ht > FILT_LEN) ? c_max_ht : FILT_LEN;
    localparam int c_cnt_w   = $clog2(c_max_all + 1);

    localparam logic [c_cnt_w-1:0] c_hold_ld   = c_cnt_w'(HOLD_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_turn_ld   = c_cnt_w'(TURN_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_filt_last = c_cnt_w'(FILT_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 r_pad_oe;
    logic                 w_pad_oe_nxt;
    logic                 r_pad_data;
    logic                 w_pad_data_nxt;

    logic                 w_inhibit;
    logic                 w_ready;
    logic                 w_xfer;
    logic                 w_mask;

    logic                 r_s1;
    logic                 r_s2;
    logic [c_cnt_w-1:0]   r_fcnt;
    logic                 r_rx_data;
    logic                 r_rx_edge;

    // ------------------------------------------------------------------
    // Transmit FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pad_oe   <= 1'b0;
            r_pad_data <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pad_oe   <= w_pad_oe_nxt;
            r_pad_data <= w_pad_data_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM: next state and handshake
    // ------------------------------------------------------------------
    always_comb begin
        w_inhibit      = por | bsr_mode;
        w_ready        = 1'b0;
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pad_oe_nxt   = r_pad_oe;
        w_pad_data_nxt = r_pad_data;

        // A new bit is only taken in IDLE or in the last hold cycle of the
        // current bit, so a bit is never cut short.
        case (r_state)
            ST_IDLE:  w_ready = ~w_inhibit;
            ST_DRIVE: w_ready = (r_cnt == '0) & ~w_inhibit;
            default:  w_ready = 1'b0;
        endcase

        w_xfer = tx_valid & w_ready;

        if (por) begin
            // Abort immediately; any bit offered this cycle is dropped
            // (w_ready is already low under por).
            w_state_nxt    = ST_IDLE;
            w_cnt_nxt      = '0;
            w_pad_oe_nxt   = 1'b0;
            w_pad_data_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        w_state_nxt    = ST_DRIVE;
                        w_pad_oe_nxt   = 1'b1;
                        w_pad_data_nxt = tx_data;
                        w_cnt_nxt      = c_hold_ld;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - c_one;
                    end else if (w_xfer) begin
                        // Back-to-back bit: oe stays high without a gap.
                        w_pad_data_nxt = tx_data;
                        w_cnt_nxt      = c_hold_ld;
                    end else begin
                        w_state_nxt  = ST_TURN;
                        w_pad_oe_nxt = 1'b0;
                        w_cnt_nxt    = c_turn_ld;
                    end
                end
                ST_TURN: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - c_one;
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = '0;
                    w_pad_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive path: 2-flop synchroniser plus persistence filter.
    // While we drive the pad (and during turnaround, while the line is
    // still settling) the receiver only sees our own echo, so the filter
    // is held in its reset count and rx_data is frozen.
    // ------------------------------------------------------------------
    assign w_mask = r_pad_oe | (r_state == ST_TURN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_fcnt    <= '0;
            r_rx_data <= 1'b0;
            r_rx_edge <= 1'b0;
        end else begin
            r_s1      <= rcvr_in;
            r_s2      <= r_s1;
            r_rx_edge <= 1'b0;
            if (w_mask) begin
                r_fcnt <= '0;
            end else if (r_s2 != r_rx_data) begin
                if (r_fcnt == c_filt_last) begin
                    r_rx_data <= r_s2;
                    r_fcnt    <= '0;
                    r_rx_edge <= 1'b1;
                end else begin
                    r_fcnt <= r_fcnt + c_one;
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_ready = w_ready & ~reset;
    assign busy     = (r_state == ST_DRIVE) | (r_state == ST_TURN);
    assign pad_oe   = r_pad_oe;
    assign pad_data = r_pad_data;
    assign rx_data  = r_rx_data;
    assign rx_edge  = r_rx_edge;

endmodule
`default_nettype wire

// File: tb/tb_bw_io_cmos_pad_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bw_io_cmos_pad_ctl
// Purpose  : Self-checking bench for bw_io_cmos_pad_ctl. A timestamp model
//            (cycle numbers at which the current bit stops driving and the
//            turnaround ends) predicts the transmit outputs; the receive
//            model decides a change by looking back over a window of
//            recorded synchronised samples. Directed scenarios with literal
//            expectations are followed by a randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bw_io_cmos_pad_ctl;

    localparam int HOLD = 2;
    localparam int TURN = 1;
    localparam int FILT = 3;
    localparam int NCYC = 8192;

    logic clk = 1'b0;
    logic reset, por, bsr_mode, tx_valid, tx_data, rcvr_in;
    logic tx_ready, pad_data, pad_oe, rx_data, rx_edge, busy;

    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state. Cycle n is the interval following the n-th rising edge.
    int   cyc       = 0;
    int   drive_end = -100;  // last cycle pad_oe is high
    int   turn_end  = -100;  // last cycle busy is high
    logic m_bit     = 1'b0;
    logic m_zero    = 1'b1;  // pad_data known to be cleared by reset/por
    logic m_rx      = 1'b0;
    logic m_edge    = 1'b0;
    logic chk_en    = 1'b0;
    bit   rin [NCYC];        // rcvr_in as captured by the first sync flop
    bit   unm [NCYC];        // filter free to count at this edge

    bit b2b_d   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit b2b_rdy [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bit b2b_pd  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    bw_io_cmos_pad_ctl #(
        .HOLD_CYC (HOLD),
        .TURN_CYC (TURN),
        .FILT_LEN (FILT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .por      (por),
        .bsr_mode (bsr_mode),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .pad_data (pad_data),
        .pad_oe   (pad_oe),
        .rcvr_in  (rcvr_in),
        .rx_data  (rx_data),
        .rx_edge  (rx_edge),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    // Ready may be given in the last hold cycle of a bit or once idle.
    function automatic logic exp_ready(input int c);
        return !reset && !por && !bsr_mode && (c == drive_end || c > turn_end);
    endfunction

    // Advance the model across one rising edge using the inputs of the
    // cycle that edge closes.
    task automatic model_edge();
        int   n;
        logic xfer;
        logic chg;
        xfer   = tx_valid && exp_ready(cyc);
        n      = cyc + 1;
        rin[n] = reset ? 1'b0 : rcvr_in;
        unm[n] = !reset && !(cyc <= turn_end);
        if (reset) begin
            m_rx   = 1'b0;
            m_edge = 1'b0;
        end else begin
            // Change when the last FILT unmasked filter samples (each one is
            // rcvr_in two edges earlier) all differ from the current level.
            chg = 1'b1;
            for (int j = 0; j < FILT; j++) begin
                if (n - 2 - j < 0 || !unm[n - j] || rin[n - 2 - j] == m_rx)
                    chg = 1'b0;
            end
            m_edge = chg;
            if (chg) m_rx = ~m_rx;
        end
        if (reset || por) begin
            drive_end = n - 1;
            turn_end  = n - 1;
            m_zero    = 1'b1;
        end else if (xfer) begin
            drive_end = n + HOLD - 1;
            turn_end  = drive_end + TURN;
            m_bit     = tx_data;
            m_zero    = 1'b0;
        end
        cyc = n;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic setin(input logic v, input logic d, input logic p,
                         input logic b, input logic rc);
        tx_valid = v;
        tx_data  = d;
        por      = p;
        bsr_mode = b;
        rcvr_in  = rc;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_ready", tx_ready, exp_ready(cyc));
            chk("pad_oe",   pad_oe,   cyc <= drive_end);
            chk("busy",     busy,     cyc <= turn_end);
            if (cyc <= drive_end) chk("pad_data", pad_data, m_bit);
            else if (m_zero)      chk("pad_data_clr", pad_data, 1'b0);
            chk("rx_data",  rx_data,  m_rx);
            chk("rx_edge",  rx_edge,  m_edge);
        end
    end

    initial begin
        logic v, d, b, rc;
        int   por_cnt;

        reset = 1'b1;
        setin(0, 0, 0, 0, 0);
        step();
        chk_en = 1'b1;
        #1 chk("ready_in_reset", tx_ready, 1'b0);
        step(); step(); step();
        reset = 1'b0;
        #1 chk("ready_after_reset", tx_ready, 1'b1);
        step(); step();

        // ---- single bit ----
        setin(1, 1, 0, 0, 0);
        #1 chk("sb_ready_idle", tx_ready, 1'b1);
        step();
        setin(0, 0, 0, 0, 0);
        #1 chk("sb_c1_oe", pad_oe, 1'b1);
        chk("sb_c1_data", pad_data, 1'b1);
        chk("sb_c1_ready", tx_ready, 1'b0);
        step();
        #1 chk("sb_c2_oe", pad_oe, 1'b1);
        chk("sb_c2_data", pad_data, 1'b1);
        step();
        #1 chk("sb_c3_oe", pad_oe, 1'b0);
        chk("sb_c3_busy", busy, 1'b1);
        chk("sb_c3_ready", tx_ready, 1'b0);
        step();
        #1 chk("sb_c4_ready", tx_ready, 1'b1);
        chk("sb_c4_busy", busy, 1'b0);

        // ---- back-to-back burst 1,0,1 ----
        for (int k = 0; k < 6; k++) begin
            setin(1, b2b_d[k], 0, 0, 0);
            #1 chk("b2b_ready", tx_ready, b2b_rdy[k]);
            step();
            #1 chk("b2b_oe", pad_oe, 1'b1);
            chk("b2b_data", pad_data, b2b_pd[k]);
        end
        setin(0, 0, 0, 0, 0);
        #1 chk("b2b_last_ready", tx_ready, 1'b1);
        step();
        #1 chk("b2b_oe_fall", pad_oe, 1'b0);
        chk("b2b_turn_busy", busy, 1'b1);
        step(); step();

        // ---- glitch filter ----
        setin(0, 0, 0, 0, 1);
        step(); step();
        setin(0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) step();
        #1 chk("glitch_rx", rx_data, 1'b0);
        setin(0, 0, 0, 0, 1);
        step(); step(); step(); step();
        #1 chk("clean_rx_early", rx_data, 1'b0);
        step();
        #1 chk("clean_rx", rx_data, 1'b1);
        chk("clean_edge", rx_edge, 1'b1);
        step();
        #1 chk("clean_edge_pulse", rx_edge, 1'b0);
        setin(0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) step();
        #1 chk("rx_back_low", rx_data, 1'b0);

        // ---- echo mask: 4-bit burst with rcvr_in toggling ----
        for (int k = 0; k < 7; k++) begin
            setin(1, k[0], 0, 0, k[0]);
            step();
            #1 chk("echo_rx_frozen", rx_data, 1'b0);
            chk("echo_no_edge", rx_edge, 1'b0);
        end
        setin(0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) step();
        #1 chk("echo_rx_wait", rx_data, 1'b0);
        step();
        #1 chk("echo_rx_after", rx_data, 1'b1);
        chk("echo_edge_after", rx_edge, 1'b1);
        setin(0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) step();

        // ---- por abort in second hold cycle ----
        setin(1, 1, 0, 0, 0);
        step();
        setin(0, 0, 0, 0, 0);
        step();
        setin(0, 0, 1, 0, 0);
        #1 chk("por_ready", tx_ready, 1'b0);
        step();
        #1 chk("por_oe", pad_oe, 1'b0);
        chk("por_data", pad_data, 1'b0);
        chk("por_ready_held", tx_ready, 1'b0);
        step();
        setin(0, 0, 0, 0, 0);
        #1 chk("por_release_ready", tx_ready, 1'b1);
        chk("por_release_busy", busy, 1'b0);
        step(); step();

        // ---- bsr_mode during first hold cycle ----
        setin(1, 1, 0, 0, 0);
        step();
        setin(1, 0, 0, 1, 0);
        #1 chk("bsr_c1_ready", tx_ready, 1'b0);
        step();
        #1 chk("bsr_c2_oe", pad_oe, 1'b1);
        chk("bsr_c2_data", pad_data, 1'b1);
        chk("bsr_c2_ready", tx_ready, 1'b0);
        step();
        #1 chk("bsr_turn_oe", pad_oe, 1'b0);
        chk("bsr_turn_busy", busy, 1'b1);
        step();
        #1 chk("bsr_idle_ready", tx_ready, 1'b0);
        step();
        setin(0, 0, 0, 0, 0);
        #1 chk("bsr_release_ready", tx_ready, 1'b1);
        step(); step();

        // ---- randomized run ----
        b       = 1'b0;
        rc      = 1'b0;
        por_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 9) < 7);
            d = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) por_cnt = $urandom_range(1, 3);
            if ($urandom_range(0, 39) == 0) b = ~b;
            if ($urandom_range(0, 5) == 0) rc = ~rc;
            reset = (i >= 1500 && i < 1503);
            setin(v, d, (por_cnt > 0), b, rc);
            if (por_cnt > 0) por_cnt--;
            step();
        end
        reset = 1'b0;
        setin(0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bw_io_cmos_pad_ctl.md
Name: bw_io_cmos_pad_ctl

Overview:
Sequencing controller for one bidirectional CMOS pad slice built on the CMOS edge logic cell. It accepts transmit bits from core logic through a valid/ready handshake and drives the edge cell's data/oe pins for a programmable hold time. It inserts bus-turnaround cycles before releasing the pad. It synchronises and glitch-filters the receiver path (edge cell to_core) and masks the pad's own echo while driving. Power-on reset (por) and boundary-scan mode (bsr_mode) safely abort or inhibit driving.

Parameters:
HOLD_CYC, 2, cycles each transmitted bit is held on the pad (>=1)
TURN_CYC, 1, cycles oe is held low after a burst before the next accept (>=1)
FILT_LEN, 3, consecutive identical synchronised samples required to change rx_data (>=1)

Ports:
clk  in  1  core clock; all state is on the rising edge
reset  in  1  synchronous, active-high reset
por  in  1  power-on reset indication from the edge cell, active high
bsr_mode  in  1  boundary-scan mode; inhibits new transmits
tx_valid  in  1  core has a bit to send
tx_data  in  1  bit to send
tx_ready  out  1  controller accepts tx_data this cycle
pad_data  out  1  to edge cell data input
pad_oe  out  1  to edge cell oe input
rcvr_in  in  1  from edge cell to_core (asynchronous to clk)
rx_data  out  1  filtered received level
rx_edge  out  1  one-cycle pulse when rx_data changes
busy  out  1  high in DRIVE or TURN

Behaviour:
- Reset (reset=1 at a clk edge): state=IDLE, cnt=0, pad_oe=0, pad_data=0, sync flops=0, filter count=0, rx_data=0, rx_edge=0. tx_ready is 0 during the reset cycle.
- pad_data, pad_oe, rx_data and rx_edge are registered. tx_ready and busy are combinational from the registered state.
- Counter width is clog2(max(HOLD_CYC,TURN_CYC,FILT_LEN)+1).
- inhibit = por | bsr_mode.
- A transfer occurs when tx_valid & tx_ready are both 1 at a clk edge.
- FSM states are IDLE, DRIVE and TURN.
- IDLE:
  - tx_ready = ~inhibit.
  - On transfer: go to DRIVE, pad_oe<=1, pad_data<=tx_data, cnt<=HOLD_CYC-1.
  - Latency: a bit accepted at edge k is on the pad from cycle k+1 through k+HOLD_CYC.
- DRIVE:
  - pad_oe=1. pad_data is stable while cnt>0, and cnt decrements each cycle.
  - tx_ready = (cnt==0) & ~inhibit.
  - At cnt==0 with a transfer: load the new bit, cnt<=HOLD_CYC-1, stay in DRIVE. Back-to-back bits keep pad_oe continuous with no gap.
  - At cnt==0 with no transfer: go to TURN, pad_oe<=0, cnt<=TURN_CYC-1.
- TURN:
  - pad_oe=0, tx_ready=0.
  - At cnt==0 go to IDLE; otherwise decrement.
  - A new bit is accepted no earlier than TURN_CYC+1 cycles after pad_oe falls.
- bsr_mode asserted mid-DRIVE: the current bit completes its full hold, then the FSM enters TURN (tx_ready stays 0). Bits are never truncated.
- por asserted in any state: at the next edge state<=IDLE, pad_oe<=0, pad_data<=0, cnt<=0. tx_ready stays 0 while por=1. por takes priority over a simultaneous transfer; that bit is dropped and not accepted.
- reset has priority over por.
- Receive path:
  - rcvr_in passes through a 2-flop synchroniser (s1, s2).
  - The filter compares s2 with rx_data.
    - If they differ, fcnt increments.
    - If they are equal, fcnt<=0.
    - When a differing sample arrives with fcnt==FILT_LEN-1: rx_data<=s2, fcnt<=0, rx_edge<=1 for one cycle.
  - Input-to-rx_data latency for a clean edge is 2+FILT_LEN cycles.
  - Echo mask: while pad_oe=1 or state==TURN, fcnt is held at 0, rx_data is frozen and rx_edge=0. The synchroniser keeps running.
  - por does not affect the receive path; only reset clears it.

Test Plan:
- Single bit: reset, then tx_valid=1, tx_data=1 for one cycle (edge 0) -> pad_oe=1, pad_data=1 in cycles 1-2; pad_oe=0, busy=1 in cycle 3; tx_ready=1 again in cycle 4.
- Back-to-back burst 1,0,1 with tx_valid held -> pad_oe high for exactly 6 contiguous cycles, pad_data=1,1,0,0,1,1; tx_ready high only in the IDLE cycle and on cycles with cnt==0.
- Glitch filter (pad idle): rcvr_in 0->1 for 2 cycles then back -> rx_data stays 0, no rx_edge. rcvr_in 0->1 held -> rx_data=1 and a one-cycle rx_edge exactly 5 cycles after the input edge.
- Echo mask: rcvr_in toggles while driving a 4-bit burst -> rx_data and rx_edge unchanged until TURN ends; the filter restarts from fcnt=0.
- por abort: por=1 in the 2nd cycle of a bit's hold -> pad_oe=0, pad_data=0 next cycle, tx_ready=0 while por=1; after por falls, tx_ready=1 in IDLE with no TURN cycle.
- bsr_mode: assert during the first hold cycle of a bit -> bit completes both hold cycles, TURN follows, and tx_ready stays 0 until bsr_mode=0.
